izh_neuron_array_engine: RTL and testbench

//  Time-multiplexed Izhikevich update engine for NUM_NEURONS neurons with v/w state held internally.

---
 rtl/izh_neuron_array_engine.sv | 210 +++++++++++++++++++++
 tb/tb_izh_neuron_array_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_neuron_array_engine.sv
// Time-multiplexed Izhikevich v/w update engine: one neuron issued per cycle into a 3-stage pipeline.
// Build macro IZH_SATURATE_EN: every mult/add clamps to the N-bit range instead of wrapping.
module izh_neuron_array_engine #(
  parameter int N           = 20,
  parameter int Q           = 10,
  parameter int NUM_NEURONS = 8,
  parameter logic signed [N-1:0] A      = N'(20),
  parameter logic signed [N-1:0] B      = N'(205),
  parameter logic signed [N-1:0] C      = N'(-66560),
  parameter logic signed [N-1:0] D      = N'(8192),
  parameter logic signed [N-1:0] V_PEAK = N'(30720),
  parameter logic signed [N-1:0] V_INIT = N'(-66560),
  parameter logic signed [N-1:0] W_INIT = N'(-13312),
  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic signed [N-1:0] step,
  output logic [IW-1:0]       i_idx,
  output logic                i_req,
  input  logic signed [N-1:0] i_in,
  output logic                upd_valid,
  output logic [IW-1:0]       upd_idx,
  output logic signed [N-1:0] upd_v,
  output logic                spike,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  // state | meaning
  // IDLE  | waiting for tick
  // ISSUE | one neuron per cycle enters the pipeline
  // DRAIN | last neuron in flight, leave on its writeback
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [IW-1:0]       LAST  = IW'(NUM_NEURONS - 1);
  localparam logic signed [N-1:0] K_004 = N'(((1 << Q) * 4 + 50) / 100);
  localparam logic signed [N-1:0] K_5   = N'(5 << Q);
  localparam logic signed [N-1:0] K_140 = N'(140 << Q);
`ifdef IZH_SATURATE_EN
  localparam logic signed [2*N:0] SMAX  = (2*N+1)'((1 << (N-1)) - 1);
  localparam logic signed [2*N:0] SMIN  = -SMAX - 1;
`endif

  function automatic logic signed [N-1:0] fit(input logic signed [2*N:0] x);
`ifdef IZH_SATURATE_EN
    if (x > SMAX)      return SMAX[N-1:0];
    else if (x < SMIN) return SMIN[N-1:0];
    else               return x[N-1:0];
`else
    return x[N-1:0];
`endif
  endfunction

  function automatic logic signed [N-1:0] mulq(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = (2*N)'(a) * (2*N)'(b);
    p = p >>> Q;
    return fit({p[2*N-1], p});
  endfunction

  function automatic logic signed [N-1:0] addq(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    return fit((2*N+1)'(a) + (2*N+1)'(b));
  endfunction

  function automatic logic signed [N-1:0] subq(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    return fit((2*N+1)'(a) - (2*N+1)'(b));
  endfunction

  state_t state, state_nx;
  logic [IW-1:0]       idx;
  logic signed [N-1:0] step_q;
  logic                last_issue;

  logic signed [N-1:0] v_mem [NUM_NEURONS];
  logic signed [N-1:0] w_mem [NUM_NEURONS];
  logic signed [N-1:0] v_rd, w_rd;

  logic                p1_valid;
  logic [IW-1:0]       p1_idx;
  logic signed [N-1:0] p1_v, p1_w, p1_i, p1_vv, p1_v5, p1_bv;
  logic                p2_valid;
  logic [IW-1:0]       p2_idx;
  logic signed [N-1:0] p2_v, p2_w, p2_sv, p2_su;
  logic signed [N-1:0] sv, su, dv, dw, vn, wn;
  logic                fire;

  assign last_issue = (idx == LAST);
  assign i_idx      = idx;
  assign v_rd       = v_mem[idx];
  assign w_rd       = w_mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick)       state_nx = ISSUE;
      ISSUE:   if (last_issue) state_nx = DRAIN;
      DRAIN:   if (done)       state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_comb begin
    i_req = (state == ISSUE);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      step_q  <= '0;
      overrun <= 1'b0;
    end else begin
      if (tick && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && tick) begin
        step_q <= step;
        idx    <= '0;
      end else if (state == ISSUE) begin
        idx <= last_issue ? '0 : idx + 1'b1;
      end
    end
  end

  // S1: products that depend only on the stored v
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_idx   <= '0;
      p1_v     <= '0;
      p1_w     <= '0;
      p1_i     <= '0;
      p1_vv    <= '0;
      p1_v5    <= '0;
      p1_bv    <= '0;
    end else begin
      p1_valid <= i_req;
      if (i_req) begin
        p1_idx <= idx;
        p1_v   <= v_rd;
        p1_w   <= w_rd;
        p1_i   <= i_in;
        p1_vv  <= mulq(v_rd, v_rd);
        p1_v5  <= mulq(v_rd, K_5);
        p1_bv  <= mulq(B, v_rd);
      end
    end
  end

  assign sv = addq(subq(addq(addq(mulq(p1_vv, K_004), p1_v5), K_140), p1_w), p1_i);
  assign su = subq(p1_bv, p1_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_valid <= 1'b0;
      p2_idx   <= '0;
      p2_v     <= '0;
      p2_w     <= '0;
      p2_sv    <= '0;
      p2_su    <= '0;
    end else begin
      p2_valid <= p1_valid;
      if (p1_valid) begin
        p2_idx <= p1_idx;
        p2_v   <= p1_v;
        p2_w   <= p1_w;
        p2_sv  <= sv;
        p2_su  <= su;
      end
    end
  end

  assign dv   = mulq(p2_sv, step_q);
  assign dw   = mulq(mulq(A, p2_su), step_q);
  assign vn   = addq(p2_v, dv);
  assign wn   = addq(p2_w, dw);
  assign fire = (vn >= V_PEAK);

  // S3: writeback with spike reset; each neuron is touched once per sweep so no hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k] <= V_INIT;
        w_mem[k] <= W_INIT;
      end
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_v     <= '0;
      spike     <= 1'b0;
      done      <= 1'b0;
    end else begin
      upd_valid <= p2_valid;
      spike     <= p2_valid & fire;
      done      <= p2_valid && (p2_idx == LAST);
      if (p2_valid) begin
        upd_idx        <= p2_idx;
        upd_v          <= fire ? C : vn;
        v_mem[p2_idx]  <= fire ? C : vn;
        w_mem[p2_idx]  <= fire ? addq(wn, D) : wn;
      end
    end
  end

endmodule

// File: tb/tb_izh_neuron_array_engine.sv
// Self-checking bench for izh_neuron_array_engine: randomized sweeps against a plain-arithmetic neuron model.
module tb_izh_neuron_array_engine;
  localparam int NN = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick = 1'b0;
  logic signed [19:0] step = '0;
  logic [2:0]         i_idx;
  logic               i_req;
  logic signed [19:0] i_in = '0;
  logic               upd_valid;
  logic [2:0]         upd_idx;
  logic signed [19:0] upd_v;
  logic               spike, busy, done, overrun;

  int checks = 0;
  int failures = 0;

  longint vm [NN];
  longint wm [NN];
  longint ev [NN];
  bit     es [NN];
  longint cur [NN];
  bit     spk_seen [NN];
  longint v_seen [NN];
  bit     exp_ovr;

  izh_neuron_array_engine dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .step(step),
    .i_idx(i_idx), .i_req(i_req), .i_in(i_in),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_v(upd_v),
    .spike(spike), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Q10 fixed-point arithmetic on 20-bit values, wrap or clamp per build
  function automatic longint fitm(input longint x);
    longint m;
`ifdef IZH_SATURATE_EN
    if (x > 524287) return 524287;
    if (x < -524288) return -524288;
    return x;
`else
    m = x & 64'hFFFFF;
    if (m >= 524288) m = m - 1048576;
    return m;
`endif
  endfunction

  function automatic longint mulm(input longint a, input longint b);
    return fitm((a * b) >>> 10);
  endfunction

  function automatic longint addm(input longint a, input longint b);
    return fitm(a + b);
  endfunction

  function automatic longint subm(input longint a, input longint b);
    return fitm(a - b);
  endfunction

  function automatic longint wrap20(input longint x);
    longint m;
    m = x & 64'hFFFFF;
    if (m >= 524288) m = m - 1048576;
    return m;
  endfunction

  // dv sum without the current term
  function automatic longint pre_x(input int k);
    return subm(addm(addm(mulm(mulm(vm[k], vm[k]), 41), mulm(vm[k], 5120)), 143360), wm[k]);
  endfunction

  function automatic void model_update(input int k, input longint i, input longint stp);
    longint s, u, vn, wn;
    s  = addm(pre_x(k), i);
    u  = subm(mulm(205, vm[k]), wm[k]);
    vn = addm(vm[k], mulm(s, stp));
    wn = addm(wm[k], mulm(mulm(20, u), stp));
    if (vn >= 30720) begin
      vm[k] = -66560;
      wm[k] = addm(wn, 8192);
      es[k] = 1'b1;
    end else begin
      vm[k] = vn;
      wm[k] = wn;
      es[k] = 1'b0;
    end
    ev[k] = vm[k];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NN; k++) begin
      vm[k] = -66560;
      wm[k] = -13312;
      cur[k] = 0;
    end
    exp_ovr = 1'b0;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    tick  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One full sweep starting with tick in the current cycle (cycle 0); extra = cycle of a second tick or -1
  task automatic do_sweep(input longint stp, input int extra);
    bit eb, ed, ev_ok;
    int k;
    step = 20'(stp);
    tick = 1'b1;
    for (int cyc = 1; cyc <= NN + 4; cyc++) begin
      @(posedge clk);
      #1;
      tick = (cyc == extra);
      if (cyc == extra && cyc <= NN + 3) exp_ovr = 1'b1;
      step = 20'($urandom);
      eb = (cyc <= NN + 3);
      checks++;
      if (busy !== eb) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, eb);
      end
      if (cyc <= NN) begin
        checks++;
        if (i_req !== 1'b1 || i_idx !== 3'(cyc - 1)) begin
          failures++;
          $display("FAIL issue cyc=%0d got req=%0b idx=%0d exp req=1 idx=%0d", cyc, i_req, i_idx, cyc - 1);
        end
        i_in = 20'(cur[cyc - 1]);
        model_update(cyc - 1, cur[cyc - 1], stp);
      end else begin
        checks++;
        if (i_req !== 1'b0) begin
          failures++;
          $display("FAIL i_req_idle cyc=%0d got=%0b exp=0", cyc, i_req);
        end
        i_in = 20'($urandom);
      end
      ev_ok = (cyc >= 4 && cyc <= NN + 3);
      checks++;
      if (upd_valid !== ev_ok) begin
        failures++;
        $display("FAIL upd_valid cyc=%0d got=%0b exp=%0b", cyc, upd_valid, ev_ok);
      end
      if (ev_ok) begin
        k = cyc - 4;
        spk_seen[k] = spike;
        v_seen[k] = longint'(upd_v);
        checks++;
        if (upd_idx !== 3'(k) || upd_v !== 20'(ev[k]) || spike !== es[k]) begin
          failures++;
          $display("FAIL writeback cyc=%0d got idx=%0d v=%0d spk=%0b exp idx=%0d v=%0d spk=%0b",
                   cyc, upd_idx, upd_v, spike, k, ev[k], es[k]);
        end
      end
      ed = (cyc == NN + 3);
      checks++;
      if (done !== ed) begin
        failures++;
        $display("FAIL done cyc=%0d got=%0b exp=%0b", cyc, done, ed);
      end
    end
    tick = 1'b0;
    checks++;
    if (overrun !== exp_ovr) begin
      failures++;
      $display("FAIL overrun got=%0b exp=%0b", overrun, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({i_req, upd_valid, spike, busy, done, overrun} !== 6'b0 || i_idx !== 3'd0 ||
        upd_idx !== 3'd0 || upd_v !== 20'sd0) begin
      failures++;
      $display("FAIL reset_outputs got req=%0b uv=%0b spk=%0b busy=%0b done=%0b ovr=%0b idx=%0d uidx=%0d v=%0d exp all 0",
               i_req, upd_valid, spike, busy, done, overrun, i_idx, upd_idx, upd_v);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rest();
    apply_reset();
    repeat (3) do_sweep(102, -1);
  endtask

  task automatic test_drive();
    apply_reset();
    cur[3] = 10240;
    repeat (8) begin
      do_sweep(102, -1);
      for (int k = 0; k < NN; k++) begin
        if (spk_seen[k]) begin
          checks++;
          if (v_seen[k] != -66560) begin
            failures++;
            $display("FAIL drive_spike_v idx=%0d got=%0d exp=-66560", k, v_seen[k]);
          end
        end
      end
    end
  endtask

  task automatic test_threshold();
    apply_reset();
    for (int k = 0; k < NN; k++)
      cur[k] = wrap20(((k % 2 == 0) ? 30720 : 30719) - vm[k] - pre_x(k));
    do_sweep(1024, -1);
    for (int k = 0; k < NN; k++) begin
      checks++;
      if (spk_seen[k] !== (k % 2 == 0) ||
          v_seen[k] != ((k % 2 == 0) ? -66560 : 30719)) begin
        failures++;
        $display("FAIL threshold idx=%0d got spk=%0b v=%0d exp spk=%0b", k, spk_seen[k], v_seen[k], (k % 2 == 0));
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    do_sweep(102, 5);
    do_sweep(102, -1);
    apply_reset();
    do_sweep(102, NN + 3);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    repeat (6) begin
      for (int k = 0; k < NN; k++) cur[k] = longint'($urandom_range(0, 40960)) - 20480;
      do_sweep(longint'($urandom_range(1, 1024)), -1);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    repeat (2) begin
      for (int k = 0; k < NN; k++)
        cur[k] = (k % 2 == 0) ? 524287 - longint'($urandom_range(0, 1000))
                              : -524288 + longint'($urandom_range(0, 1000));
      do_sweep(1024, -1);
    end
  endtask

  task automatic test_reset_midsweep();
    apply_reset();
    step = 20'sd102;
    tick = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      tick = 1'b0;
      i_in = 20'($urandom);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || upd_valid !== 1'b0 || i_req !== 1'b0) begin
      failures++;
      $display("FAIL midsweep_reset got busy=%0b uv=%0b req=%0b exp 0", busy, upd_valid, i_req);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || upd_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midsweep_hold got busy=%0b uv=%0b done=%0b exp 0", busy, upd_valid, done);
    end
    rst_n = 1'b1;
    model_reset();
    do_sweep(102, -1);
  endtask

  initial begin
    test_reset();
    test_rest();
    test_drive();
    test_threshold();
    test_overrun();
    test_back_to_back();
    test_overflow();
    test_reset_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
